// File: rtl/cpu_mem_pkg.sv
// Shared memory-stage definitions for the load and store byte-lane paths:
// one-hot access sizes, load FSM encoding and the alignment check.
package cpu_mem_pkg;

  localparam logic [2:0] SZ_B = 3'b001;
  localparam logic [2:0] SZ_H = 3'b010;
  localparam logic [2:0] SZ_W = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } mem_state_e;

  // Bytes are never misaligned; halfwords need off[0]==0, words need off==0.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] off);
    return ((size == SZ_H) && off[0]) || ((size == SZ_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational lane select and sign/zero extension of a returned 32-bit word.
// Zero latency, no flow control; a non-one-hot size passes the word through.
module load_extract
  import cpu_mem_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  ld_type,
  input  logic        ld_unsigned,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[{off, 3'b000} +: 8];
    half_lane = off[1] ? rdata[31:16] : rdata[15:0];
    data      = rdata;
    case (ld_type)
      SZ_B:    data = {{24{~ld_unsigned & byte_lane[7]}}, byte_lane};
      SZ_H:    data = {{16{~ld_unsigned & half_lane[15]}}, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Load request -> word-aligned addr_ok/data_ok read -> extended writeback value; misaligned loads
// answer with ALE after 1 cycle; addr_ok and resp_ready may stall indefinitely, one load in flight.
module load_unit
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_type,
  input  logic              req_unsigned,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_ale
);

  mem_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        type_q, type_d;
  logic              unsigned_q, unsigned_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ale_q, ale_d;
  logic [DATA_W-1:0] ext_data;

  load_extract u_extract (
    .off         (addr_q[1:0]),
    .ld_type     (type_q),
    .ld_unsigned (unsigned_q),
    .rdata       (mem_rdata),
    .data        (ext_data)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    type_d     = type_q;
    unsigned_d = unsigned_q;
    data_d     = data_q;
    ale_d      = ale_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d     = req_addr;
          type_d     = req_type;
          unsigned_d = req_unsigned;
          if (is_misaligned(req_type, req_addr[1:0])) begin
            ale_d   = 1'b1;
            data_d  = '0;
            state_d = RESP;
          end else begin
            ale_d   = 1'b0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem_addr_ok) state_d = WAIT;
      end
      // Only WAIT listens to data_ok, so stray or abandoned returns are dropped.
      WAIT: begin
        if (mem_data_ok) begin
          data_d  = ext_data;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      type_q     <= '0;
      unsigned_q <= 1'b0;
      data_q     <= '0;
      ale_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      type_q     <= type_d;
      unsigned_q <= unsigned_d;
      data_q     <= data_d;
      ale_q      <= ale_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign mem_req    = (state_q == REQ);
  assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
  assign resp_valid = (state_q == RESP);
  assign resp_data  = data_q;
  assign resp_ale   = ale_q;

endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Load-side counterpart of the store byte-lane formatter in the CPU memory stage.
- Accepts one load request from the pipeline and issues a word-aligned read on the data-SRAM-style addr_ok/data_ok interface.
- Extracts the addressed byte, halfword or word from the returned word and sign- or zero-extends it.
- Returns a 32-bit writeback value, or flags an address-error (ALE) without accessing memory.

Parameters:
- ADDR_W, 32, address width of req_addr and mem_addr.
- DATA_W, 32, data width; fixed at 32, since lane logic assumes 4 byte lanes.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  load request valid
- req_ready  output  1  unit can accept a request (high only in IDLE)
- req_addr  input  ADDR_W  byte address
- req_type  input  3  one-hot size: [0] byte, [1] half, [2] word
- req_unsigned  input  1  1 = zero-extend (LBU/LHU); ignored for word
- mem_req  output  1  memory read request, held until mem_addr_ok
- mem_addr  output  ADDR_W  word-aligned address, with low 2 bits forced to 0
- mem_addr_ok  input  1  memory accepted address this cycle
- mem_data_ok  input  1  mem_rdata valid this cycle
- mem_rdata  input  DATA_W  read word
- resp_valid  output  1  result valid, held until resp_ready
- resp_ready  input  1  writeback consumes result
- resp_data  output  DATA_W  extended load value (0 when resp_ale)
- resp_ale  output  1  misaligned-address error for this response

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high, named reset.
- Reset values: state=IDLE; req_ready=1 (combinational from state); mem_req=0; resp_valid=0; resp_ale=0; resp_data=0; internal addr/type/unsigned/data registers=0.
- State IDLE: req_ready=1. On req_valid, latch addr, type and unsigned.
  - Misaligned request (half with addr[0]=1, or word with addr[1:0]!=0): go to RESP with ale=1 and data=0. No mem_req is issued.
  - Aligned request: go to REQ.
- State REQ: mem_req=1; mem_addr = {addr[ADDR_W-1:2],2'b00}. On mem_addr_ok, go to WAIT. Address and mem_req are stable while waiting.
- State WAIT: mem_req=0. On mem_data_ok, register the extracted value and go to RESP. mem_data_ok is ignored in every state other than WAIT. The memory side never returns data in the same cycle as addr_ok.
- State RESP: resp_valid=1; resp_data and resp_ale are stable. On resp_ready, go to IDLE.
  - No new request is accepted in RESP. There is one bubble cycle between back-to-back loads.
- Latency: request accepted at edge N gives mem_req in cycle N+1. With same-cycle addr_ok and data_ok one cycle later, resp_valid is high in cycle N+3. A misaligned request gives resp_valid in cycle N+1.
- Extraction, with off = addr[1:0]:
  - byte: lane = rdata[8*off+7:8*off]; upper 24 bits = unsigned ? 0 : lane[7].
  - half: lane = off[1] ? rdata[31:16] : rdata[15:0]; upper 16 bits = unsigned ? 0 : lane[15].
  - word: rdata unchanged.
- A req_type that is not one-hot is illegal. The bench asserts on it; RTL behaviour is don't-care.
- Reset mid-operation returns immediately to IDLE with all outputs at reset values. The outstanding memory transaction is abandoned; a later mem_data_ok is ignored because the unit is not in WAIT.
- Back-pressure: mem_addr_ok and resp_ready may stay low indefinitely. The unit holds its state with no timeout.

Decomposition:
- Shared package cpu_mem_pkg holds:
  - one-hot size constants SZ_B=3'b001, SZ_H=3'b010, SZ_W=3'b100, shared with the store path;
  - the FSM state encoding (IDLE, REQ, WAIT, RESP);
  - a misalign-check function used by both load and store paths.
- One combinational sub-module, load_extract (inputs off, type, unsigned, rdata; output data). It is instantiated in load_unit and reusable by a future uncached path.

Test Plan:
- LB at addr 0x1003, rdata=0x80FF_1234 -> mem_addr=0x1000, resp_data=0xFFFF_FF80, ale=0; resp_valid exactly 3 cycles after accept when addr_ok and data_ok are immediate.
- LHU at 0x2002, rdata=0x9ABC_5678 -> resp_data=0x0000_9ABC. LH with the same stimulus -> 0xFFFF_9ABC.
- LW at 0x3001 -> resp_ale=1, resp_data=0, mem_req never asserted, resp_valid 1 cycle after accept.
- LW at 0x4000 with mem_addr_ok delayed 5 cycles and resp_ready delayed 3 -> mem_req held 6 cycles with a stable address; resp_data=rdata held until resp_ready; req_ready low throughout.
- Reset asserted in WAIT, with mem_data_ok pulsing afterwards -> all outputs at reset values, no resp_valid; next LBU at 0x10 with rdata=0x0000_00A5 -> 0x0000_00A5.
- Spurious mem_data_ok while in IDLE or REQ -> no state change and no response.
